// File: rtl/axi_defines.sv
// Shared AXI constants: response codes used by every AXI4-Lite endpoint.
package axi_defines;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
endpackage

// File: rtl/axil_ram_slave_pkg.sv
// Local helpers for the AXI4-Lite RAM responder.
package axil_ram_slave_pkg;
    import axi_defines::*;

    localparam int STRB_WIDTH = 4;

    function automatic logic [1:0] resp_of(input logic ok);
        return ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
    endfunction
endpackage

// File: rtl/axil_ram_bank.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module axil_ram_bank #(
    parameter int DEPTH_WORDS = 8192,
    parameter int INIT_ZERO   = 1,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH_WORDS] =
        '{default: {32{(INIT_ZERO != 0) ? 1'b0 : 1'bx}}};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Old word is returned when a write hits the same address this edge.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite responder backed by a byte-strobed word RAM; one outstanding op per channel.
module axil_ram_slave
    import axil_ram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 8192,
    parameter int INIT_ZERO   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic                  aw_held, aw_ok;
    logic [IDX_W-1:0]      aw_idx;
    logic                  w_held;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  ar_pend, ar_ok, r_ok;
    logic [IDX_W-1:0]      ar_idx;
    logic [31:0]           bank_q;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic                  unused_prot;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> 2) < ADDR_WIDTH'(DEPTH_WORDS);
    endfunction

    assign unused_prot    = ^{s_axil_awprot, s_axil_arprot};
    assign s_axil_awready = !rst && !aw_held;
    assign s_axil_wready  = !rst && !w_held;
    assign s_axil_arready = !rst && !s_axil_rvalid && !ar_pend;
    assign aw_hs  = s_axil_awvalid && s_axil_awready;
    assign w_hs   = s_axil_wvalid && s_axil_wready;
    assign ar_hs  = s_axil_arvalid && s_axil_arready;
    assign commit = aw_held && w_held && !s_axil_bvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held <= 1'b0;
            aw_ok   <= 1'b0;
            aw_idx  <= '0;
            w_held  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_ok   <= in_range(s_axil_awaddr);
                aw_idx  <= s_axil_awaddr[IDX_W+1:2];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= 2'b00;
        end else if (commit) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= resp_of(aw_ok);
        end else if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_pend       <= 1'b0;
            ar_ok         <= 1'b0;
            ar_idx        <= '0;
            r_ok          <= 1'b0;
            s_axil_rvalid <= 1'b0;
            s_axil_rresp  <= 2'b00;
        end else begin
            if (ar_hs) begin
                ar_pend <= 1'b1;
                ar_ok   <= in_range(s_axil_araddr);
                ar_idx  <= s_axil_araddr[IDX_W+1:2];
            end
            if (ar_pend) begin
                ar_pend       <= 1'b0;
                r_ok          <= ar_ok;
                s_axil_rvalid <= 1'b1;
                s_axil_rresp  <= resp_of(ar_ok);
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

    // Bank output only reloads on in-range reads, so masking keeps rdata stable.
    assign s_axil_rdata = r_ok ? bank_q : '0;

    axil_ram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_ZERO   (INIT_ZERO)
    ) u_bank (
        .clk   (clk),
        .we    (commit && aw_ok),
        .waddr (aw_idx),
        .wdata (w_data),
        .wstrb (w_strb),
        .re    (ar_pend && ar_ok),
        .raddr (ar_idx),
        .rdata (bank_q)
    );
endmodule

// File: tb/tb_axil_ram_slave.sv
// Self-checking bench for axil_ram_slave: vector table, corner sequences, random traffic.
module tb_axil_ram_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [8192];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } tv_t;
    tv_t tv [11];

    always #5 clk = ~clk;

    axil_ram_slave dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(3'b000),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    task automatic model_wr(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        if (addr < 32'h8000)
            ref_mem[int'(addr >> 2)] = merge(ref_mem[int'(addr >> 2)], data, strb);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [1:0] resp,
                      output int lat);
        logic a, w;
        bit got = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1; wvalid = 1; bready = 1;
        lat = 0; resp = 2'b01;
        for (int n = 0; n < 40 && !got; n++) begin
            a = awready; w = wready;
            nxt();
            lat++;
            if (a) awvalid = 0;
            if (w) wvalid = 0;
            if (bvalid) begin
                resp = bresp;
                got = 1;
                nxt();
            end
        end
        awvalid = 0; wvalid = 0; bready = 0;
        if (!got) chk("write timeout", 32'(got), 32'd1);
        model_wr(addr, data, strb);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data,
                      output logic [1:0] resp, output int lat);
        logic a;
        bit got = 0;
        araddr = addr; arvalid = 1; rready = 1;
        lat = 0; resp = 2'b01; data = 'x;
        for (int n = 0; n < 40 && !got; n++) begin
            a = arready;
            nxt();
            lat++;
            if (a) arvalid = 0;
            if (rvalid) begin
                data = rdata;
                resp = rresp;
                got = 1;
                nxt();
            end
        end
        arvalid = 0; rready = 0;
        if (!got) chk("read timeout", 32'(got), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] d, addr;
        int          lat;

        foreach (ref_mem[i]) ref_mem[i] = '0;
        tv[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'hDEAD_BEEF, 2'b00};
        tv[1]  = '{32'h0000_0010, 32'h1122_3344, 4'h5, 2'b00, 32'hDE22_BE44, 2'b00};
        tv[2]  = '{32'h0000_0013, 32'hA5A5_A5A5, 4'h0, 2'b00, 32'hDE22_BE44, 2'b00};
        tv[3]  = '{32'h0000_0000, 32'h0F0F_0F0F, 4'hF, 2'b00, 32'h0F0F_0F0F, 2'b00};
        tv[4]  = '{32'h0000_8000, 32'hCAFE_F00D, 4'hF, 2'b11, 32'h0000_0000, 2'b11};
        tv[5]  = '{32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0F0F_0F0F, 2'b00};
        tv[6]  = '{32'h0000_7FFC, 32'h0BAD_C0DE, 4'hF, 2'b00, 32'h0BAD_C0DE, 2'b00};
        tv[7]  = '{32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 2'b11, 32'h0000_0000, 2'b11};
        tv[8]  = '{32'h0000_8010, 32'h9999_9999, 4'hF, 2'b11, 32'h0000_0000, 2'b11};
        tv[9]  = '{32'h0000_0010, 32'h0000_0000, 4'h0, 2'b00, 32'hDE22_BE44, 2'b00};
        tv[10] = '{32'h0000_0004, 32'hAABB_CCDD, 4'hA, 2'b00, 32'hAA00_CC00, 2'b00};

        // reset state
        #12;
        chk("awready in reset", 32'(awready), 0);
        chk("wready in reset", 32'(wready), 0);
        chk("arready in reset", 32'(arready), 0);
        chk("bvalid in reset", 32'(bvalid), 0);
        chk("rvalid in reset", 32'(rvalid), 0);
        chk("rdata in reset", rdata, 0);
        chk("bresp/rresp in reset", 32'({bresp, rresp}), 0);
        nxt();
        rst = 0;
        #1;
        chk("readies after reset", 32'({awready, wready, arready}), 32'h7);

        // vector table: write then read back each entry
        foreach (tv[i]) begin
            wr(tv[i].addr, tv[i].data, tv[i].strb, resp, lat);
            chk($sformatf("tv%0d bresp", i), 32'(resp), 32'(tv[i].bresp));
            chk($sformatf("tv%0d b latency", i), 32'(lat), 2);
            rd(tv[i].addr, d, resp, lat);
            chk($sformatf("tv%0d rdata", i), d, tv[i].rdata);
            chk($sformatf("tv%0d rresp", i), 32'(resp), 32'(tv[i].rresp));
            chk($sformatf("tv%0d r latency", i), 32'(lat), 2);
        end

        // W three cycles ahead of AW, then a stalled B with a second write queued
        bready = 0;
        wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1;
        chk("seqA wready", 32'(wready), 1);
        nxt();
        wvalid = 0;
        chk("seqA w held", 32'(wready), 0);
        nxt();
        nxt();
        awaddr = 32'h20; awvalid = 1;
        chk("seqA awready", 32'(awready), 1);
        nxt();
        awvalid = 0;
        chk("seqA no early b", 32'(bvalid), 0);
        nxt();
        chk("seqA bvalid", 32'(bvalid), 1);
        chk("seqA bresp", 32'(bresp), 0);
        model_wr(32'h20, 32'h55, 4'hF);
        awaddr = 32'h24; wdata = 32'h0000_0066; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("seqA b held", 32'(bvalid), 1);
            nxt();
            if (i == 0) begin
                awvalid = 0;
                wvalid = 0;
            end
        end
        chk("seqA 2nd held", 32'({awready, wready}), 0);
        bready = 1;
        nxt();
        chk("seqA b cleared", 32'(bvalid), 0);
        nxt();
        chk("seqA 2nd bvalid", 32'(bvalid), 1);
        nxt();
        bready = 0;
        chk("seqA 2nd b done", 32'(bvalid), 0);
        model_wr(32'h24, 32'h66, 4'hF);
        rd(32'h20, d, resp, lat);
        chk("seqA word 0x20", d, 32'h55);
        rd(32'h24, d, resp, lat);
        chk("seqA word 0x24", d, 32'h66);

        // R stalled four cycles while another AR waits
        rready = 0;
        araddr = 32'h20; arvalid = 1;
        nxt();
        arvalid = 0;
        nxt();
        chk("seqB rvalid", 32'(rvalid), 1);
        araddr = 32'h24; arvalid = 1;
        for (int i = 0; i < 4; i++) begin
            chk("seqB rdata stable", rdata, 32'h55);
            chk("seqB rresp stable", 32'(rresp), 0);
            chk("seqB arready low", 32'(arready), 0);
            nxt();
        end
        rready = 1;
        nxt();
        chk("seqB r done", 32'(rvalid), 0);
        chk("seqB arready after r", 32'(arready), 1);
        nxt();
        arvalid = 0;
        nxt();
        chk("seqB 2nd rvalid", 32'(rvalid), 1);
        chk("seqB 2nd rdata", rdata, 32'h66);
        nxt();
        rready = 0;

        // reset with only the AW half of a write captured
        wr(32'h30, 32'h1234_5678, 4'hF, resp, lat);
        awaddr = 32'h30; awvalid = 1;
        nxt();
        awvalid = 0;
        chk("seqC aw held", 32'({awready, wready}), 32'h1);
        rst = 1;
        #1;
        chk("seqC readies forced", 32'({awready, wready, arready}), 0);
        nxt();
        rst = 0;
        #1;
        chk("seqC readies back", 32'({awready, wready, arready}), 32'h7);
        chk("seqC responses dropped", 32'({bvalid, rvalid}), 0);
        nxt();
        nxt();
        chk("seqC no commit", 32'(bvalid), 0);
        rd(32'h30, d, resp, lat);
        chk("seqC ram kept", d, 32'h1234_5678);

        // random traffic against the reference array
        for (int i = 0; i < 10000; i++) begin
            addr = ($urandom_range(0, 8191) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                wr(addr, $urandom, 4'($urandom_range(0, 15)), resp, lat);
                chk("rand bresp", 32'(resp), 0);
            end else begin
                rd(addr, d, resp, lat);
                chk("rand rdata", d, ref_mem[int'(addr >> 2)]);
                chk("rand rresp", 32'(resp), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
